// File: rtl/mem_stage.sv
// LC-3b pipeline memory stage: data-memory access (LDR/STR, LDB/STB, LDI/STI)
// with upstream stall, plus the MEM/WB pipeline register feeding write_back.

package lc3b_types;

    // Control word carried down the pipeline; this stage decodes only the
    // memory fields and forwards the whole word to write_back.
    typedef struct packed {
        logic       load_regfile;
        logic       load_cc;
        logic [1:0] regfilemux_sel;
        logic       mem_read;
        logic       mem_write;
        logic       mem_byte;
        logic       indirect;
    } lc3b_control_word;

endpackage

module mem_stage
    import lc3b_types::*;
#(
    parameter bit LDB_SEXT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    // EX/MEM pipeline register
    input  logic             ex_valid,
    input  lc3b_control_word ex_cw,
    input  logic [15:0]      ex_npc,
    input  logic [15:0]      ex_result,
    input  logic [15:0]      ex_src,
    input  logic [15:0]      ex_ir,
    input  logic [2:0]       ex_dr,
    output logic             mem_stall,
    // Data memory
    output logic             dmem_read,
    output logic             dmem_write,
    output logic [15:0]      dmem_address,
    output logic [15:0]      dmem_wdata,
    output logic [1:0]       dmem_byte_enable,
    input  logic             dmem_resp,
    input  logic [15:0]      dmem_rdata,
    // MEM/WB pipeline register
    output logic [15:0]      wb_mem_address,
    output logic [15:0]      wb_data,
    output logic [15:0]      wb_npc,
    output logic [15:0]      wb_result,
    output logic [15:0]      wb_ir,
    output lc3b_control_word wb_cw,
    output logic [2:0]       wb_dr,
    output logic             wb_valid
);

    typedef enum logic {
        IDLE,
        IND
    } state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [14:0] r_ptr_word;     // indirect pointer; bit 0 is never used since the second access is a word
    logic        w_memop;
    logic        w_ind;
    logic        w_word;
    logic [7:0]  w_load_byte;
    logic [15:0] w_byte_ext;
    logic [15:0] w_load_data;

    // Decode of the memory-operation class of the instruction sitting in EX/MEM.
    assign w_memop = ex_valid & (ex_cw.mem_read | ex_cw.mem_write);
    assign w_ind   = w_memop & ex_cw.indirect;
    assign w_word  = ex_cw.indirect | ~ex_cw.mem_byte;

    // Load formatting: byte lane picked by the effective address, then extended.
    assign w_load_byte = ex_result[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];
    assign w_byte_ext  = LDB_SEXT ? {{8{w_load_byte[7]}}, w_load_byte}
                                  : {8'h00, w_load_byte};
    assign w_load_data = (ex_valid & ex_cw.mem_read) ? (w_word ? dmem_rdata : w_byte_ext)
                                                     : 16'h0000;

    // State register and the captured indirect pointer.
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ptr_word <= 15'h0000;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE && w_ind && dmem_resp) begin
                r_ptr_word <= dmem_rdata[15:1];
            end
        end
    end

    // Next-state, memory request and stall generation.
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        w_state_next     = r_state;
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_address     = {ex_result[15:1], 1'b0};
        dmem_wdata       = ex_src;
        dmem_byte_enable = 2'b11;
        mem_stall        = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_memop) begin
                    // Indirects always start with a word read of the pointer.
                    dmem_read  = ex_cw.mem_read | ex_cw.indirect;
                    dmem_write = ex_cw.mem_write & ~ex_cw.indirect;
                    if (!w_word) begin
                        dmem_address = ex_result;
                        dmem_wdata   = {ex_src[7:0], ex_src[7:0]};
                        if (ex_cw.mem_write) begin
                            dmem_byte_enable = ex_result[0] ? 2'b10 : 2'b01;
                        end
                    end
                    mem_stall = ~(dmem_resp & ~ex_cw.indirect);
                    if (dmem_resp && ex_cw.indirect) begin
                        w_state_next = IND;
                    end
                end
            end
            IND: begin
                dmem_address = {r_ptr_word, 1'b0};
                dmem_read    = ex_cw.mem_read;
                dmem_write   = ex_cw.mem_write & ~ex_cw.mem_read;
                mem_stall    = ~dmem_resp;
                if (dmem_resp) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase

        // An access in flight is abandoned the moment reset asserts.
        if (!rst_n) begin
            dmem_read  = 1'b0;
            dmem_write = 1'b0;
        end
    end

    // MEM/WB register: load when not stalled, otherwise insert a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_mem_address <= 16'h0000;
            wb_data        <= 16'h0000;
            wb_npc         <= 16'h0000;
            wb_result      <= 16'h0000;
            wb_ir          <= 16'h0000;
            wb_cw          <= '0;
            wb_dr          <= 3'd0;
            wb_valid       <= 1'b0;
        end else if (!mem_stall) begin
            wb_mem_address <= ex_result;
            wb_data        <= w_load_data;
            wb_npc         <= ex_npc;
            wb_result      <= ex_result;
            wb_ir          <= ex_ir;
            wb_cw          <= ex_cw;
            wb_dr          <= ex_dr;
            wb_valid       <= ex_valid;
        end else begin
            wb_valid <= 1'b0;
            wb_cw    <= '0;
        end
    end

endmodule
